// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO with internal storage, registered read port, wrap-bit pointers,
// occupancy thresholds and sticky overflow/underflow flags.
module sync_fifo_mem #(
    parameter int unsigned Data_Width = 8,
    parameter int unsigned Addr_Width = 4,
    parameter int unsigned Depth      = 16,
    parameter int unsigned AF_Level   = 12,
    parameter int unsigned AE_Level   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [Data_Width-1:0] data_in,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [Data_Width-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [Addr_Width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    if (Depth != (1 << Addr_Width)) begin : g_bad_depth
        $error("sync_fifo_mem: Depth must equal 2**Addr_Width");
    end
    if (AF_Level < 1 || AF_Level > Depth) begin : g_bad_af
        $error("sync_fifo_mem: AF_Level out of range 1..Depth");
    end
    if (AE_Level > Depth - 1) begin : g_bad_ae
        $error("sync_fifo_mem: AE_Level out of range 0..Depth-1");
    end

    localparam logic [Addr_Width:0] DepthV = (Addr_Width+1)'(Depth);
    localparam logic [Addr_Width:0] AfV    = (Addr_Width+1)'(AF_Level);
    localparam logic [Addr_Width:0] AeV    = (Addr_Width+1)'(AE_Level);

    logic [Data_Width-1:0] mem [Depth];
    logic [Addr_Width:0]   wr_ptr;
    logic [Addr_Width:0]   rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    always_comb begin
        count        = wr_ptr - rd_ptr;
        full         = (count == DepthV);
        empty        = (count == '0);
        almost_full  = (count >= AfV);
        almost_empty = (count <= AeV);
        rd_acc       = rd_en & ~empty;
        wr_acc       = wr_en & (~full | rd_en);
    end

    // Storage is deliberately not reset; empty prevents stale words from being read.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr[Addr_Width-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            data_out  <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Non-blocking read of the old word gives read-before-write on a shared index.
            if (rd_acc) begin
                data_out <= mem[rd_ptr[Addr_Width-1:0]];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            overflow  <= (overflow & ~clr_err) | (wr_en & ~wr_acc);
            underflow <= (underflow & ~clr_err) | (rd_en & ~rd_acc);
        end
    end

endmodule

// File: tb/tb_sync_fifo_mem.sv
// Scoreboard bench for sync_fifo_mem: a queue-based reference FIFO predicts every
// read word and flag; a negedge monitor compares the DUT against it.
module tb_sync_fifo_mem;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] data_in = '0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q [$];
    logic [7:0] exp_q  [$];
    bit         m_ovf = 0;
    bit         m_udf = 0;
    bit         exp_valid = 0;
    logic [7:0] last_dout = '0;
    bit         armed = 0;

    sync_fifo_mem #(
        .Data_Width(8),
        .Addr_Width(4),
        .Depth(16),
        .AF_Level(12),
        .AE_Level(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .data_in(data_in),
        .rd_en(rd_en),
        .clr_err(clr_err),
        .data_out(data_out),
        .rd_valid(rd_valid),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus; the reference model commits at the same clock edge.
    task automatic cycle(input bit wr, input logic [7:0] d, input bit rd, input bit clr, input bit rs);
        bit rdacc;
        bit wracc;
        rst = rs; wr_en = wr; data_in = d; rd_en = rd; clr_err = clr;
        @(posedge clk);
        if (rs) begin
            fifo_q.delete();
            exp_q.delete();
            m_ovf = 0;
            m_udf = 0;
            exp_valid = 0;
            last_dout = '0;
        end else begin
            rdacc = rd && (fifo_q.size() > 0);
            wracc = wr && ((fifo_q.size() < 16) || rd);
            exp_valid = rdacc;
            if (rdacc) exp_q.push_back(fifo_q.pop_front());
            if (wracc) fifo_q.push_back(d);
            m_ovf = (m_ovf && !clr) || (wr && !wracc);
            m_udf = (m_udf && !clr) || (rd && !rdacc);
        end
        armed = 1;
        #1;
        rst = 0; wr_en = 0; rd_en = 0; clr_err = 0;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("count", int'(count), fifo_q.size());
            chk("full", int'(full), int'(fifo_q.size() == 16));
            chk("empty", int'(empty), int'(fifo_q.size() == 0));
            chk("almost_full", int'(almost_full), int'(fifo_q.size() >= 12));
            chk("almost_empty", int'(almost_empty), int'(fifo_q.size() <= 2));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underflow", int'(underflow), int'(m_udf));
            chk("rd_valid", int'(rd_valid), int'(exp_valid));
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", 1, 0);
                end else begin
                    last_dout = exp_q.pop_front();
                    chk("read_data", int'(data_out), int'(last_dout));
                end
            end else begin
                chk("data_hold", int'(data_out), int'(last_dout));
            end
        end
    end

    initial begin
        int n;
        @(posedge clk); #1;
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 0);

        // Fill to full
        for (int i = 1; i <= 16; i++) cycle(1, 8'(i), 0, 0, 0);
        // Rejected write, then clear
        cycle(1, 8'hAA, 0, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);
        // Simultaneous read/write while full, then drain
        cycle(1, 8'h55, 1, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        // Underflow, then write+read from empty
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        cycle(1, 8'h77, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);

        // Stream 40 words, occupancy kept between 1 and 5, across two pointer wraps
        n = 0;
        cycle(1, 8'(n), 0, 0, 0); n++;
        while (n < 40) begin
            bit w;
            bit r;
            w = (fifo_q.size() < 5) && ($urandom_range(0, 3) != 0);
            r = (fifo_q.size() > 1) && ($urandom_range(0, 2) != 0);
            if (fifo_q.size() <= 1) w = 1;
            cycle(w, 8'(n), r, 0, 0);
            if (w) n++;
        end
        while (fifo_q.size() > 0) cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);

        // Reset mid-operation at count 9 with both requests high
        for (int i = 0; i < 9; i++) cycle(1, 8'($urandom), 0, 0, 0);
        cycle(1, 8'hEE, 1, 1, 1);
        cycle(0, 8'h00, 0, 0, 0);

        // Randomized traffic with varying fill bias, error clears and rare resets
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 300) % 3;
            cycle($urandom_range(0, 3) < (bias + 1),
                  8'($urandom),
                  $urandom_range(0, 3) < (3 - bias),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 299) == 0);
        end
        while (fifo_q.size() > 0) cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_mem.md
Name: sync_fifo_mem

Overview:
Single-clock FIFO with built-in storage and a registered read port, generalised in data width and depth. It keeps its own wrap-bit read and write pointers and derives full, empty, occupancy count and almost-full/almost-empty thresholds from them. It records sticky overflow and underflow errors. It is intended as the standard same-clock-domain buffer between pipeline stages.

Parameters:
Data_Width, 8, width of one stored word in bits
Addr_Width, 4, pointer address bits; Depth = 2**Addr_Width
Depth, 16, number of words; must equal 2**Addr_Width (elaboration error otherwise)
AF_Level, 12, almost_full asserts when count >= AF_Level; legal range 1..Depth
AE_Level, 2, almost_empty asserts when count <= AE_Level; legal range 0..Depth-1

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  write request
data_in  input  Data_Width  write data
rd_en  input  1  read request
clr_err  input  1  clears the sticky overflow and underflow flags
data_out  output  Data_Width  registered read data
rd_valid  output  1  data_out holds a newly read word (one-cycle pulse per accepted read)
full  output  1  count == Depth
empty  output  1  count == 0
almost_full  output  1  count >= AF_Level
almost_empty  output  1  count <= AE_Level
count  output  Addr_Width+1  current occupancy, 0..Depth
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Pointers: wr_ptr and rd_ptr are Addr_Width+1 bits. The low Addr_Width bits address storage. The MSB is the wrap bit. Both increment modulo 2**(Addr_Width+1).
- count = wr_ptr - rd_ptr, modulo 2**(Addr_Width+1). full, empty, almost_full and almost_empty are decoded combinationally from the registered pointers only, never from wr_en or rd_en.
- rd_acc = rd_en & !empty.
- wr_acc = wr_en & (!full | rd_en). A write while full is accepted when a read is accepted in the same cycle.
- When empty and rd_en and wr_en are both high: the write is accepted, the read is rejected (underflow set), and count becomes 1.
- On wr_acc: mem[wr_ptr[Addr_Width-1:0]] <= data_in; wr_ptr increments.
- On rd_acc: data_out <= mem[rd_ptr[Addr_Width-1:0]]; rd_ptr increments; rd_valid <= 1.
- Otherwise rd_valid <= 0 and data_out holds its previous value.
- Read latency: one cycle from the rd_en edge to valid data_out.
- Simultaneous read and write to the same storage index (full with both requests): read-before-write. data_out returns the old word.
- overflow is set when wr_en & !wr_acc. underflow is set when rd_en & !rd_acc.
- Both flags hold until clr_err or rst. If a new error occurs in the same cycle as clr_err, the flag is set (set wins).
- Reset, including mid-operation: on the rst edge, both pointers return to 0, data_out = 0, rd_valid = 0, overflow = 0, underflow = 0.
- Values seen the cycle after reset: empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0.
- While rst is high, wr_en, rd_en and clr_err are ignored and no errors are recorded.
- Storage contents are not reset. Stale words are never visible, because empty blocks reads.
- Wrap-around: after 2*Depth accepted writes and reads, the pointers return to 0 with no loss of order.

Test Plan:
(All scenarios use Data_Width=8, Addr_Width=4, Depth=16, AF_Level=12, AE_Level=2.)
1. Reset, then write 0x01..0x10 on 16 consecutive cycles -> count steps 1..16; almost_empty drops at count 3; almost_full rises at count 12; full = 1 at count 16; overflow = 0.
2. From full, pulse wr_en alone with 0xAA -> write rejected; overflow = 1; count stays 16. Then pulse clr_err -> overflow = 0.
3. From full, assert wr_en=1 (0x55) and rd_en=1 together -> next cycle data_out = 0x01, rd_valid = 1, count = 16. Drain 16 reads -> sequence 0x02..0x10 then 0x55; empty = 1 after the last read.
4. From empty, rd_en=1 alone -> rd_valid stays 0, data_out unchanged, underflow = 1. Then wr_en=1 and rd_en=1 with 0x77 -> count = 1 and underflow stays 1. Next rd_en -> data_out = 0x77.
5. Stream 40 words (0x00..0x27) with interleaved reads, keeping count between 1 and 5 -> read order matches write order across two pointer wraps; no errors flagged.
6. With count = 9, assert rst for one cycle while wr_en=1 and rd_en=1 -> next cycle count = 0, empty = 1, rd_valid = 0, data_out = 0x00, no error flags.
